bcd_seq_conv: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one input bit per clock.
- Converts a BIN_W-bit operand into DIGITS packed BCD digits.
- Supports an optional two's-complement mode with a sign flag, overflow detection and a significant-digit count for display blanking.
- Sits between the calculator's arithmetic result register and the seven-segment display driver, and replaces single-cycle combinational conversion so width can grow without a deep combinational chain.

---
 rtl/bcd_seq_conv.sv | 178 +++++++++++++++++
 tb/tb_bcd_seq_conv.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential binary-to-BCD converter using shift-and-add-3.
// One operand bit is consumed per clock. In signed mode the magnitude is
// converted and the sign is reported separately on neg. Bits shifted out of
// the top digit set ovf. lead_digits gives the number of significant digits
// so the display driver can blank leading zeros.
module bcd_seq_conv #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           signed_mode,
    input  logic [BIN_W-1:0]               bin_in,
    output logic                           busy,
    output logic                           done,
    output logic [4*DIGITS-1:0]            bcd_out,
    output logic                           neg,
    output logic                           ovf,
    output logic [$clog2(DIGITS+1)-1:0]    lead_digits
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam int LW = $clog2(DIGITS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Working registers
    logic [BIN_W-1:0]  mag;
    logic [BW-1:0]     work;
    logic [CW-1:0]     cnt;
    logic              sign_pending;
    logic              ovf_sticky;

    // Control strobes from the output process
    logic              load;
    logic              step;
    logic              finish;

    // Datapath intermediates
    logic [BIN_W-1:0]  load_mag;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     work_nxt;
    logic [BIN_W-1:0]  mag_nxt;
    logic              ovf_nxt;
    logic [LW-1:0]     lead_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: control strobes and busy
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        busy   = 1'b0;
        case (state)
            IDLE: begin
                load = start;
            end
            CONV: begin
                busy   = 1'b1;
                step   = 1'b1;
                finish = (cnt == CW'(1));
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Magnitude of the incoming operand; the most-negative value maps to
    // 2^(BIN_W-1), which still fits in BIN_W unsigned bits
    always_comb begin
        load_mag = bin_in;
        if (signed_mode && bin_in[BIN_W-1]) begin
            load_mag = ~bin_in + 1'b1;
        end
    end

    // Add-3 correction on every digit, then one combined left shift of
    // {work, mag}; the bit leaving the top digit feeds the sticky overflow
    always_comb begin
        adj = work;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] > 4'd4) begin
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
        work_nxt = {adj[BW-2:0], mag[BIN_W-1]};
        mag_nxt  = {mag[BIN_W-2:0], 1'b0};
        ovf_nxt  = ovf_sticky | adj[BW-1];
    end

    // Significant-digit count of the value about to be published; zero
    // still shows one digit
    always_comb begin
        lead_nxt = LW'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work_nxt[4*i +: 4] != 4'd0) begin
                lead_nxt = LW'(i + 1);
            end
        end
    end

    // Working registers: load on accepted start, shift on each CONV cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag          <= '0;
            work         <= '0;
            cnt          <= '0;
            sign_pending <= 1'b0;
            ovf_sticky   <= 1'b0;
        end else if (load) begin
            mag          <= load_mag;
            work         <= '0;
            cnt          <= CW'(BIN_W);
            sign_pending <= signed_mode & bin_in[BIN_W-1];
            ovf_sticky   <= 1'b0;
        end else if (step) begin
            mag          <= mag_nxt;
            work         <= work_nxt;
            cnt          <= cnt - 1'b1;
            ovf_sticky   <= ovf_nxt;
        end
    end

    // Published results: updated only on the last shift step, with done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done        <= 1'b0;
            bcd_out     <= '0;
            neg         <= 1'b0;
            ovf         <= 1'b0;
            lead_digits <= LW'(1);
        end else begin
            done <= finish;
            if (finish) begin
                bcd_out     <= work_nxt;
                neg         <= sign_pending;
                ovf         <= ovf_nxt;
                lead_digits <= lead_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb_bcd_seq_conv: directed self-checking bench for bcd_seq_conv.
// Main instance uses BIN_W=16, DIGITS=5; a second DIGITS=4 instance covers
// the overflow cases.
module tb_bcd_seq_conv;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start;
    logic        signed_mode;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic        neg;
    logic        ovf;
    logic [2:0]  lead_digits;

    logic        start4;
    logic        signed_mode4;
    logic [15:0] bin_in4;
    logic        busy4;
    logic        done4;
    logic [15:0] bcd_out4;
    logic        neg4;
    logic        ovf4;
    logic [2:0]  lead_digits4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_seq_conv #(.BIN_W(16), .DIGITS(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .bin_in      (bin_in),
        .busy        (busy),
        .done        (done),
        .bcd_out     (bcd_out),
        .neg         (neg),
        .ovf         (ovf),
        .lead_digits (lead_digits)
    );

    bcd_seq_conv #(.BIN_W(16), .DIGITS(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start4),
        .signed_mode (signed_mode4),
        .bin_in      (bin_in4),
        .busy        (busy4),
        .done        (done4),
        .bcd_out     (bcd_out4),
        .neg         (neg4),
        .ovf         (ovf4),
        .lead_digits (lead_digits4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start on the selected instance and wait (bounded)
    // for done; lat is edges from the accepting edge to the done edge.
    task automatic run(input bit sel4, input logic [15:0] val, input logic sm,
                       input string tag, output int lat);
        if (sel4) begin
            start4 = 1'b1; bin_in4 = val; signed_mode4 = sm;
        end else begin
            start = 1'b1; bin_in = val; signed_mode = sm;
        end
        tick();
        check({tag, "_busy_after_start"}, sel4 ? busy4 : busy, 1);
        start = 1'b0; start4 = 1'b0;
        bin_in = 16'hxxxx; signed_mode = 1'bx;
        bin_in4 = 16'hxxxx; signed_mode4 = 1'bx;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (sel4 ? done4 : done) break;
        end
        check({tag, "_latency"}, lat, 16);
        check({tag, "_busy_at_done"}, sel4 ? busy4 : busy, 0);
    endtask

    initial begin
        int lat;
        int dcount;
        int dcycle;

        rst_n = 1'b0;
        start = 1'b0; signed_mode = 1'b0; bin_in = '0;
        start4 = 1'b0; signed_mode4 = 1'b0; bin_in4 = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_neg", neg, 0);
        check("rst_ovf", ovf, 0);
        check("rst_lead", lead_digits, 1);

        // 0xFFFF unsigned
        run(0, 16'hFFFF, 0, "u_ffff", lat);
        check("u_ffff_bcd", bcd_out, 20'h65535);
        check("u_ffff_neg", neg, 0);
        check("u_ffff_ovf", ovf, 0);
        check("u_ffff_lead", lead_digits, 5);
        tick();
        check("u_ffff_done_drop", done, 0);
        check("u_ffff_hold_bcd", bcd_out, 20'h65535);

        // Most negative signed
        run(0, 16'h8000, 1, "s_8000", lat);
        check("s_8000_bcd", bcd_out, 20'h32768);
        check("s_8000_neg", neg, 1);
        check("s_8000_ovf", ovf, 0);
        check("s_8000_lead", lead_digits, 5);

        // -1 signed
        run(0, 16'hFFFF, 1, "s_ffff", lat);
        check("s_ffff_bcd", bcd_out, 20'h00001);
        check("s_ffff_neg", neg, 1);
        check("s_ffff_lead", lead_digits, 1);

        // Zero, unsigned and signed
        run(0, 16'h0000, 0, "u_zero", lat);
        check("u_zero_bcd", bcd_out, 20'h00000);
        check("u_zero_neg", neg, 0);
        check("u_zero_ovf", ovf, 0);
        check("u_zero_lead", lead_digits, 1);
        run(0, 16'h0000, 1, "s_zero", lat);
        check("s_zero_bcd", bcd_out, 20'h00000);
        check("s_zero_neg", neg, 0);

        // Four-digit instance: overflow then exact fit
        run(1, 16'd12345, 0, "d4_12345", lat);
        check("d4_12345_bcd", bcd_out4, 16'h2345);
        check("d4_12345_ovf", ovf4, 1);
        check("d4_12345_lead", lead_digits4, 4);
        run(1, 16'd9999, 0, "d4_9999", lat);
        check("d4_9999_bcd", bcd_out4, 16'h9999);
        check("d4_9999_ovf", ovf4, 0);

        // Start ignored while busy
        start = 1'b1; bin_in = 16'd100; signed_mode = 1'b0;
        tick();
        dcount = 0;
        dcycle = 0;
        for (int c = 1; c <= 16; c++) begin
            start = (c == 3 || c == 8);
            bin_in = 16'd200;
            tick();
            if (c == 3) check("ign_busy_c3", busy, 1);
            if (done) begin
                dcount++;
                dcycle = c;
            end
        end
        check("ign_done_count", dcount, 1);
        check("ign_done_cycle", dcycle, 16);
        check("ign_bcd", bcd_out, 20'h00100);

        // Start in the done cycle is accepted
        start = 1'b1; bin_in = 16'd200; signed_mode = 1'b0;
        tick();
        check("dc_busy", busy, 1);
        check("dc_done_low", done, 0);
        start = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (done) break;
        end
        check("dc_latency", lat, 16);
        check("dc_bcd", bcd_out, 20'h00200);

        // Reset mid-conversion aborts with no done
        start = 1'b1; bin_in = 16'd54321; signed_mode = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_bcd", bcd_out, 0);
        check("ab_neg", neg, 0);
        check("ab_ovf", ovf, 0);
        check("ab_lead", lead_digits, 1);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) dcount++;
        end
        check("ab_no_done", dcount, 0);
        run(0, 16'd777, 0, "after_ab", lat);
        check("after_ab_bcd", bcd_out, 20'h00777);
        check("after_ab_lead", lead_digits, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
